// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - state type and one-hot helper shared by the decoder_scan slice
package decoder_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    SCAN   = 2'd2
  } state_t;

  localparam int MAX_N = 6;

  // Callers slice the low 2**N bits for their own select width N.
  function automatic logic [2**MAX_N-1:0] onehot(input logic [MAX_N-1:0] sel);
    onehot      = '0;
    onehot[sel] = 1'b1;
  endfunction

endpackage

// File: rtl/decoder_tick_gen.sv
// rtl/decoder_tick_gen.sv - prescaler producing one scan step strobe every SCAN_DIV cycles
module decoder_tick_gen #(
  parameter int SCAN_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int W = $clog2(SCAN_DIV) + 1;
  localparam logic [W-1:0] LAST = W'(SCAN_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q + W'(1);
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/decoder_scan.sv
// rtl/decoder_scan.sv - registered N-to-2**N decoder with an auto-scan mode
module decoder_scan
  import decoder_pkg::*;
#(
  parameter int N          = 2,
  parameter int ACTIVE_LOW = 1,
  parameter int SCAN_DIV   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [N-1:0]    sel,
  output logic [2**N-1:0] D,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int W = 2**N;

  state_t         state_q, state_d;
  logic [W-1:0]   onehot_q, onehot_d;
  logic [N-1:0]   idx_q, idx_d;
  logic           wrap_q, wrap_d;
  logic           scanning;
  logic           tick;

  // Prescaler only runs while staying in SCAN, so every entry starts from zero.
  assign scanning = (state_q == SCAN) && (state_d == SCAN);

  decoder_tick_gen #(.SCAN_DIV(SCAN_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (!scanning),
    .tick (tick)
  );

  always_comb begin
    state_d = IDLE;
    if (en) state_d = mode ? SCAN : DECODE;
  end

  always_comb begin
    onehot_d = '0;
    idx_d    = idx_q;
    wrap_d   = 1'b0;
    case (state_d)
      DECODE: idx_d = sel;
      SCAN: begin
        idx_d = '0;
        if (scanning) begin
          idx_d  = tick ? idx_q + N'(1) : idx_q;
          wrap_d = tick && (idx_q == '1);
        end
      end
      default: ;
    endcase
    if (state_d != IDLE) onehot_d = W'(onehot(MAX_N'(idx_d)));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      onehot_q <= '0;
      idx_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      onehot_q <= onehot_d;
      idx_q    <= idx_d;
      wrap_q   <= wrap_d;
    end
  end

  assign D    = (ACTIVE_LOW != 0) ? ~onehot_q : onehot_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;

endmodule

// File: tb/tb_decoder_scan.sv
// tb/tb_decoder_scan.sv - self-checking bench for decoder_scan against a cycle-count reference model
module tb_decoder_scan;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst = 1'b0;
  logic       en_a = 1'b0, mode_a = 1'b0;
  logic [1:0] sel_a = '0;
  logic       en_b = 1'b0, mode_b = 1'b0;
  logic [2:0] sel_b = '0;
  logic [3:0] d_a;
  logic [1:0] idx_a;
  logic       wrap_a;
  logic [7:0] d_b;
  logic [2:0] idx_b;
  logic       wrap_b;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within a scan is a plain cycle count since entry.
  int ma_sc = -1, ma_idx = 0;
  bit ma_act = 0, ma_wrap = 0;
  int mb_sc = -1, mb_idx = 0;
  bit mb_act = 0, mb_wrap = 0;

  decoder_scan #(.N(2), .ACTIVE_LOW(1), .SCAN_DIV(4)) dut_a (
    .clk(clk), .rst(rst), .en(en_a), .mode(mode_a), .sel(sel_a),
    .D(d_a), .idx(idx_a), .wrap(wrap_a)
  );

  decoder_scan #(.N(3), .ACTIVE_LOW(0), .SCAN_DIV(1)) dut_b (
    .clk(clk), .rst(rst), .en(en_b), .mode(mode_b), .sel(sel_b),
    .D(d_b), .idx(idx_b), .wrap(wrap_b)
  );

  initial forever #5 if (clk_run) clk = ~clk;

  function automatic logic [6:0] exp_a();
    logic [3:0] d;
    logic [1:0] i;
    i = ma_idx[1:0];
    d = ma_act ? ~(4'b0001 << i) : 4'b1111;
    return {d, i, ma_wrap};
  endfunction

  function automatic logic [11:0] exp_b();
    logic [7:0] d;
    logic [2:0] i;
    i = mb_idx[2:0];
    d = mb_act ? (8'b00000001 << i) : 8'b00000000;
    return {d, i, mb_wrap};
  endfunction

  task automatic model_reset();
    ma_sc = -1; ma_idx = 0; ma_act = 0; ma_wrap = 0;
    mb_sc = -1; mb_idx = 0; mb_act = 0; mb_wrap = 0;
  endtask

  task automatic model_step();
    ma_wrap = 0;
    if (!en_a)       begin ma_act = 0; ma_sc = -1; end
    else if (!mode_a) begin ma_act = 1; ma_sc = -1; ma_idx = sel_a; end
    else begin
      ma_act = 1; ma_sc++;
      ma_idx = (ma_sc / 4) % 4;
      ma_wrap = (ma_sc > 0) && (ma_sc % 16 == 0);
    end
    mb_wrap = 0;
    if (!en_b)       begin mb_act = 0; mb_sc = -1; end
    else if (!mode_b) begin mb_act = 1; mb_sc = -1; mb_idx = sel_b; end
    else begin
      mb_act = 1; mb_sc++;
      mb_idx = mb_sc % 8;
      mb_wrap = (mb_sc > 0) && (mb_sc % 8 == 0);
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3 rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== 7'b1111_00_0) begin
      n_fail++; $display("FAIL reset_a: got D=%b idx=%0d wrap=%b, want D=1111 idx=0 wrap=0", d_a, idx_a, wrap_a);
    end
    n_checks++;
    if ({d_b, idx_b, wrap_b} !== 12'b0) begin
      n_fail++; $display("FAIL reset_b: got D=%b idx=%0d wrap=%b, want D=00000000 idx=0 wrap=0", d_b, idx_b, wrap_b);
    end
    clk_run = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tick();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== exp_a()) begin
      n_fail++; $display("FAIL idle_after_reset: got %b, want %b", {d_a, idx_a, wrap_a}, exp_a());
    end
  endtask

  task automatic test_decode();
    en_a = 1; mode_a = 0; sel_a = 2'd2;
    tick();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== 7'b1011_10_0 || exp_a() !== 7'b1011_10_0) begin
      n_fail++; $display("FAIL decode_sel2: got D=%b idx=%0d wrap=%b, want D=1011 idx=2 wrap=0", d_a, idx_a, wrap_a);
    end
    sel_a = 2'd3;
    tick();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== 7'b0111_11_0) begin
      n_fail++; $display("FAIL decode_sel3: got D=%b idx=%0d wrap=%b, want D=0111 idx=3 wrap=0", d_a, idx_a, wrap_a);
    end
  endtask

  task automatic test_scan();
    logic [3:0] pat [5];
    pat[0] = 4'b1110; pat[1] = 4'b1101; pat[2] = 4'b1011; pat[3] = 4'b0111; pat[4] = 4'b1110;
    en_a = 1; mode_a = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (d_a !== pat[k/4] || wrap_a !== (k == 16) || {d_a, idx_a, wrap_a} !== exp_a()) begin
        n_fail++; $display("FAIL scan_step%0d: got D=%b idx=%0d wrap=%b, want D=%b wrap=%b", k, d_a, idx_a, wrap_a, pat[k/4], (k == 16));
      end
    end
  endtask

  task automatic test_mode_change();
    en_a = 1; mode_a = 0; sel_a = 2'd0;
    tick();
    mode_a = 1;
    for (int k = 0; k < 9; k++) tick();
    n_checks++;
    if (idx_a !== 2'd2) begin
      n_fail++; $display("FAIL midscan_idx: got idx=%0d, want 2", idx_a);
    end
    mode_a = 0; sel_a = 2'd1;
    tick();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== 7'b1101_01_0) begin
      n_fail++; $display("FAIL midscan_decode: got D=%b idx=%0d, want D=1101 idx=1", d_a, idx_a);
    end
    mode_a = 1;
    tick();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== 7'b1110_00_0) begin
      n_fail++; $display("FAIL rescan_restart: got D=%b idx=%0d wrap=%b, want D=1110 idx=0 wrap=0", d_a, idx_a, wrap_a);
    end
  endtask

  task automatic test_priority();
    en_a = 1; mode_a = 0; sel_a = 2'd3;
    tick();
    en_a = 0; mode_a = 1;
    tick();
    n_checks++;
    if ({d_a, idx_a, wrap_a} !== 7'b1111_11_0) begin
      n_fail++; $display("FAIL en_priority: got D=%b idx=%0d wrap=%b, want D=1111 idx=3 wrap=0", d_a, idx_a, wrap_a);
    end
  endtask

  task automatic test_fast_scan();
    en_b = 1; mode_b = 1;
    for (int k = 0; k < 20; k++) begin
      tick();
      n_checks++;
      if (d_b !== (8'b00000001 << (k % 8)) || wrap_b !== (k == 8 || k == 16) || {d_b, idx_b, wrap_b} !== exp_b()) begin
        n_fail++; $display("FAIL fast_step%0d: got D=%b idx=%0d wrap=%b, want %b", k, d_b, idx_b, wrap_b, exp_b());
      end
    end
    for (int k = 0; k < 3; k++) tick();
    rst = 1'b1;
    #1;
    model_reset();
    n_checks++;
    if ({d_b, idx_b, wrap_b} !== 12'b0) begin
      n_fail++; $display("FAIL async_reset_b: got D=%b idx=%0d wrap=%b, want all 0", d_b, idx_b, wrap_b);
    end
    #2 rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      n_checks++;
      if ({d_b, idx_b, wrap_b} !== exp_b()) begin
        n_fail++; $display("FAIL restart_b%0d: got %b, want %b", k, {d_b, idx_b, wrap_b}, exp_b());
      end
    end
    en_b = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 600; c++) begin
      en_a  = ($urandom_range(0, 15) != 0);
      en_b  = ($urandom_range(0, 15) != 0);
      if ($urandom_range(0, 24) == 0) mode_a = ~mode_a;
      if ($urandom_range(0, 9) == 0)  mode_b = ~mode_b;
      sel_a = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1;
        #1;
        model_reset();
        #1 rst = 1'b0;
      end
      tick();
      n_checks++;
      if ({d_a, idx_a, wrap_a} !== exp_a()) begin
        n_fail++; $display("FAIL random_a cycle %0d: got %b, want %b", c, {d_a, idx_a, wrap_a}, exp_a());
      end
      n_checks++;
      if ({d_b, idx_b, wrap_b} !== exp_b()) begin
        n_fail++; $display("FAIL random_b cycle %0d: got %b, want %b", c, {d_b, idx_b, wrap_b}, exp_b());
      end
    end
  endtask

  initial begin
    test_reset();
    test_decode();
    test_scan();
    test_mode_change();
    test_priority();
    test_fast_scan();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/decoder_scan.md
DECODER_SCAN -- requirements
Module: decoder_scan

Interface
REQ-001 Parameter N, default 2: select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter ACTIVE_LOW, default 1: 1 = selected output driven 0 and others 1; 0 = inverted polarity.
REQ-003 Parameter SCAN_DIV, default 4: clock cycles per scan step; legal range 1..65535.
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 en  input  1  enable; 0 forces all outputs inactive.
REQ-007 mode  input  1  0 = registered decode, 1 = auto-scan.
REQ-008 sel  input  N  decode address; used in decode mode only.
REQ-009 D  output  2**N  one-hot decoded output, polarity per ACTIVE_LOW, registered.
REQ-010 idx  output  N  index currently asserted on D, registered.
REQ-011 wrap  output  1  one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-012 States: IDLE, DECODE, SCAN; the state register updates every clock edge.
REQ-013 Next state: en=0 -> IDLE; en=1 and mode=0 -> DECODE; en=1 and mode=1 -> SCAN; this applies from any state.
REQ-014 IDLE: D all inactive; idx holds its value; wrap=0; prescaler and scan index cleared to 0.
REQ-015 DECODE: on each edge, D = one-hot(sel) and idx = sel; latency 1 cycle from sel/en/mode to D.
REQ-016 Entering SCAN from IDLE or DECODE: the first SCAN cycle shows idx=0 with D bit 0 active, and the prescaler starts at 0.
REQ-017 SCAN: the prescaler counts 0..SCAN_DIV-1; when the count is SCAN_DIV-1, the next edge advances idx by 1 and reloads the prescaler to 0.
REQ-018 SCAN_DIV=1: idx advances on every edge while in SCAN.
REQ-019 Wrap-around: the advance from 2**N-1 to 0 sets wrap=1 for exactly the cycle in which idx=0 is first shown; otherwise wrap=0.
REQ-020 A mode change mid-scan takes effect on the next edge; scan progress is discarded, and a later return to SCAN restarts at idx=0.
REQ-021 en deasserted and mode changed in the same cycle: en has priority and the next state is IDLE.
REQ-022 D SHALL be exactly one-hot (or all-inactive in IDLE) on every cycle; no glitch states are visible at register outputs.
REQ-023 Prescaler width is clog2(SCAN_DIV)+1 bits; idx arithmetic is modulo 2**N.

Reset
REQ-024 While rst=1: state=IDLE, D all inactive (all 1s if ACTIVE_LOW=1, all 0s otherwise), idx=0, wrap=0, prescaler=0.
REQ-025 Reset takes effect immediately and independently of clk; operation resumes on the first edge after rst falls.
REQ-026 Reset asserted mid-scan aborts the scan; a later SCAN restarts per REQ-016.

Structure
REQ-027 Package decoder_pkg holds the state enumeration (IDLE, DECODE, SCAN) and a one-hot decode function parameterised by N.
REQ-028 Sub-module decoder_tick_gen (parameter SCAN_DIV; ports clk, rst, clr, tick) generates the scan step strobe; it is the only sub-module.
REQ-029 Output polarity is applied in one place, after the one-hot register value and before D.

Verification (N=2, ACTIVE_LOW=1, SCAN_DIV=4 unless stated)
REQ-030 Assert rst with no clock -> D=4'b1111, idx=0, wrap=0 immediately.
REQ-031 en=1, mode=0, sel=2 -> after 1 edge D=4'b1011, idx=2; sel=3 -> next edge D=4'b0111.
REQ-032 en=1, mode=1 for 20 cycles -> D sequence 1110, 1101, 1011, 0111, 1110, each held 4 cycles; wrap=1 only in the first cycle of the second 1110.
REQ-033 Mid-scan at idx=2, set mode=0 with sel=1 -> next edge D=4'b1101; set mode=1 again -> D=4'b1110, idx=0.
REQ-034 en=0 and mode=1 in the same cycle during DECODE -> next edge D=4'b1111, wrap=0.
REQ-035 SCAN_DIV=1, ACTIVE_LOW=0, N=3 -> D steps 00000001 to 10000000 on consecutive edges; wrap pulses every 8 cycles; rst mid-sequence gives D=0 asynchronously.
